// File: rtl/bp_me_dev_steer.sv
// -----------------------------------------------------------------------------
// bp_me_dev_steer
//
// Routes memory command headers from one upstream port to either a device
// port or a loopback tie-off port, chosen by the command address. The device
// claims one naturally aligned, power-of-2 sized region. Every other address
// goes to loopback, so unmapped commands are drained instead of stalling the
// network. Each loopback-routed command is counted in a saturating error
// counter.
//
// Responses return upstream strictly in command order. A small tag FIFO
// records the target of every accepted command. The head tag picks which
// response source is forwarded and acknowledged. The other source is held.
//
// Ports
//   clk_i, reset_i                     clock; async active-high reset
//   mem_cmd_header_i/_critical_i/_v_i  upstream command
//   mem_cmd_header_ready_and_o         upstream command ready
//   dev_cmd_* / lb_cmd_*               device / loopback command outputs
//   dev_cmd_header_ready_and_i         device command ready
//   lb_cmd_header_ready_and_i          loopback command ready
//   dev_resp_* / lb_resp_*             device / loopback response inputs
//   dev_resp_header_ready_and_o        device response ready
//   lb_resp_header_ready_and_o         loopback response ready
//   mem_resp_header_o/_critical_o/_v_o upstream response
//   mem_resp_header_ready_and_i        upstream response ready
//   err_cnt_o                          saturating count of loopback commands
// -----------------------------------------------------------------------------
module bp_me_dev_steer #(
    parameter int paddr_width_p      = 40,
    parameter int mem_header_width_p = 64,
    parameter int dword_width_p      = 64,
    // bit position of the physical address inside the command header
    parameter int addr_lsb_p         = 8,
    parameter int els_p              = 4,
    parameter logic [paddr_width_p-1:0] dev_base_p = '0,
    parameter logic [paddr_width_p-1:0] dev_size_p = 'h1000,
    parameter int err_cnt_width_p    = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic [mem_header_width_p-1:0] mem_cmd_header_i,
    input  logic [dword_width_p-1:0]      mem_cmd_critical_i,
    input  logic                          mem_cmd_header_v_i,
    output logic                          mem_cmd_header_ready_and_o,

    output logic [mem_header_width_p-1:0] dev_cmd_header_o,
    output logic [dword_width_p-1:0]      dev_cmd_critical_o,
    output logic                          dev_cmd_header_v_o,
    input  logic                          dev_cmd_header_ready_and_i,

    output logic [mem_header_width_p-1:0] lb_cmd_header_o,
    output logic [dword_width_p-1:0]      lb_cmd_critical_o,
    output logic                          lb_cmd_header_v_o,
    input  logic                          lb_cmd_header_ready_and_i,

    input  logic [mem_header_width_p-1:0] dev_resp_header_i,
    input  logic [dword_width_p-1:0]      dev_resp_critical_i,
    input  logic                          dev_resp_header_v_i,
    output logic                          dev_resp_header_ready_and_o,

    input  logic [mem_header_width_p-1:0] lb_resp_header_i,
    input  logic [dword_width_p-1:0]      lb_resp_critical_i,
    input  logic                          lb_resp_header_v_i,
    output logic                          lb_resp_header_ready_and_o,

    output logic [mem_header_width_p-1:0] mem_resp_header_o,
    output logic [dword_width_p-1:0]      mem_resp_critical_o,
    output logic                          mem_resp_header_v_o,
    input  logic                          mem_resp_header_ready_and_i,

    output logic [err_cnt_width_p-1:0]    err_cnt_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;

    // Clearing the offset bits leaves the region-select bits, which must
    // equal the (aligned) base for the device to claim the address.
    localparam logic [paddr_width_p-1:0] dev_mask_lp =
        ~(dev_size_p - paddr_width_p'(1));

    // -------------------------------------------------------------------------
    // Tag FIFO state
    // -------------------------------------------------------------------------
    logic [els_p-1:0]    tag_mem;   // 1 = device, 0 = loopback
    logic [ptr_w_lp-1:0] wr_ptr;
    logic [ptr_w_lp-1:0] rd_ptr;
    logic [cnt_w_lp-1:0] tag_cnt;
    logic                tag_full;
    logic                tag_empty;
    logic                head_dev;

    assign tag_full  = (tag_cnt == cnt_w_lp'(els_p));
    assign tag_empty = (tag_cnt == '0);
    assign head_dev  = tag_mem[rd_ptr];

    // -------------------------------------------------------------------------
    // Command path: combinational, unbuffered
    // -------------------------------------------------------------------------
    logic [paddr_width_p-1:0] cmd_addr;
    logic                     sel_dev;
    logic                     cmd_open;
    logic                     push;

    assign cmd_addr = mem_cmd_header_i[addr_lsb_p +: paddr_width_p];
    assign sel_dev  = ((cmd_addr & dev_mask_lp) == dev_base_p);

    // A full FIFO closes the port even when a pop lands in the same cycle.
    // This keeps the upstream ready free of any path from the response side.
    assign cmd_open = ~reset_i & ~tag_full;

    assign dev_cmd_header_o   = mem_cmd_header_i;
    assign dev_cmd_critical_o = mem_cmd_critical_i;
    assign lb_cmd_header_o    = mem_cmd_header_i;
    assign lb_cmd_critical_o  = mem_cmd_critical_i;

    assign dev_cmd_header_v_o = mem_cmd_header_v_i & cmd_open &  sel_dev;
    assign lb_cmd_header_v_o  = mem_cmd_header_v_i & cmd_open & ~sel_dev;

    assign mem_cmd_header_ready_and_o = cmd_open &
        (sel_dev ? dev_cmd_header_ready_and_i : lb_cmd_header_ready_and_i);

    assign push = mem_cmd_header_v_i & mem_cmd_header_ready_and_o;

    // -------------------------------------------------------------------------
    // Response path: head tag selects the only source that may be acked
    // -------------------------------------------------------------------------
    logic pop;

    assign mem_resp_header_o   = head_dev ? dev_resp_header_i   : lb_resp_header_i;
    assign mem_resp_critical_o = head_dev ? dev_resp_critical_i : lb_resp_critical_i;
    assign mem_resp_header_v_o = ~tag_empty &
        (head_dev ? dev_resp_header_v_i : lb_resp_header_v_i);

    assign dev_resp_header_ready_and_o = ~tag_empty &  head_dev & mem_resp_header_ready_and_i;
    assign lb_resp_header_ready_and_o  = ~tag_empty & ~head_dev & mem_resp_header_ready_and_i;

    assign pop = mem_resp_header_v_o & mem_resp_header_ready_and_i;

    // -------------------------------------------------------------------------
    // Tag FIFO update
    // -------------------------------------------------------------------------
    // Tag storage is plain data: it is only ever read under a non-zero count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr] <= sel_dev;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            // els_p is a power of 2, so the pointers wrap naturally.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Error counter: loopback-routed commands, saturating at all-ones
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_cnt_o <= '0;
        end else if (push && !sel_dev && !(&err_cnt_o)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

`ifndef SYNTHESIS
    no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push && tag_full));
    no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(pop && tag_empty));
`endif

endmodule

// File: tb/tb_bp_me_dev_steer.sv
module tb_bp_me_dev_steer;

    localparam int PW = 40;
    localparam int HW = 64;
    localparam int DW = 64;
    localparam logic [PW-1:0] BASE = 40'h00_0010_0000;
    localparam logic [PW-1:0] SIZE = 40'h00_0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [HW-1:0] cmd_hdr = '0;
    logic [DW-1:0] cmd_crit = '0;
    logic          cmd_v = 1'b0;
    logic          cmd_rdy;
    logic [HW-1:0] dev_hdr;
    logic [DW-1:0] dev_crit;
    logic          dev_v;
    logic          dev_rdy = 1'b1;
    logic [HW-1:0] lb_hdr;
    logic [DW-1:0] lb_crit;
    logic          lb_v;
    logic          lb_rdy = 1'b1;
    logic [HW-1:0] dresp_hdr = 64'hD0D0_0000_0000_00D1;
    logic [DW-1:0] dresp_crit = 64'h0000_0000_0000_00DC;
    logic          dresp_v = 1'b0;
    logic          dresp_rdy;
    logic [HW-1:0] lresp_hdr = 64'h1B1B_0000_0000_001B;
    logic [DW-1:0] lresp_crit = 64'h0000_0000_0000_001C;
    logic          lresp_v = 1'b0;
    logic          lresp_rdy;
    logic [HW-1:0] resp_hdr;
    logic [DW-1:0] resp_crit;
    logic          resp_v;
    logic          resp_rdy = 1'b0;
    logic [1:0]    err_cnt;

    int total = 0;
    int bad = 0;

    bp_me_dev_steer #(
        .paddr_width_p(PW), .mem_header_width_p(HW), .dword_width_p(DW),
        .addr_lsb_p(8), .els_p(4), .dev_base_p(BASE), .dev_size_p(SIZE),
        .err_cnt_width_p(2)
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .mem_cmd_header_i(cmd_hdr), .mem_cmd_critical_i(cmd_crit),
        .mem_cmd_header_v_i(cmd_v), .mem_cmd_header_ready_and_o(cmd_rdy),
        .dev_cmd_header_o(dev_hdr), .dev_cmd_critical_o(dev_crit),
        .dev_cmd_header_v_o(dev_v), .dev_cmd_header_ready_and_i(dev_rdy),
        .lb_cmd_header_o(lb_hdr), .lb_cmd_critical_o(lb_crit),
        .lb_cmd_header_v_o(lb_v), .lb_cmd_header_ready_and_i(lb_rdy),
        .dev_resp_header_i(dresp_hdr), .dev_resp_critical_i(dresp_crit),
        .dev_resp_header_v_i(dresp_v), .dev_resp_header_ready_and_o(dresp_rdy),
        .lb_resp_header_i(lresp_hdr), .lb_resp_critical_i(lresp_crit),
        .lb_resp_header_v_i(lresp_v), .lb_resp_header_ready_and_o(lresp_rdy),
        .mem_resp_header_o(resp_hdr), .mem_resp_critical_o(resp_crit),
        .mem_resp_header_v_o(resp_v), .mem_resp_header_ready_and_i(resp_rdy),
        .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] addr;
        logic          v;
        logic          dr;
        logic          lr;
        logic          e_dev;
        logic          e_lb;
        logic          e_rdy;
        logic [1:0]    e_err;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [HW-1:0] mk_hdr(input logic [PW-1:0] addr, input int tag);
        return {16'(tag), addr, 8'h5A};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] addr, input int tag);
        cmd_hdr  = mk_hdr(addr, tag);
        cmd_crit = 64'hC0DE_0000_0000_0000 + 64'(tag);
        cmd_v    = 1'b1;
    endtask

    initial begin
        logic exp_src[3];
        //            addr                v     dr    lr    dev   lb    rdy   err
        vecs[0] = '{BASE + SIZE,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
        vecs[1] = '{BASE + 40'hFF8,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
        vecs[2] = '{BASE - 40'h8,       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[3] = '{BASE + 40'h10,      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[4] = '{40'h0,              1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
        vecs[5] = '{BASE,               1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
        exp_src[0] = 1'b0;
        exp_src[1] = 1'b0;
        exp_src[2] = 1'b1;

        // Reset state, with a command already presented upstream
        send(BASE + 40'h8, 1);
        tick();
        tick();
        #2;
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_dev_v", dev_v, 0);
        chk("rst_lb_v", lb_v, 0);
        chk("rst_resp_v", resp_v, 0);
        chk("rst_dresp_rdy", dresp_rdy, 0);
        chk("rst_lresp_rdy", lresp_rdy, 0);
        chk("rst_err", err_cnt, 0);
        tick();
        rst = 1'b0;

        // Single device command and its response
        #2;
        chk("a_dev_v", dev_v, 1);
        chk("a_lb_v", lb_v, 0);
        chk("a_cmd_rdy", cmd_rdy, 1);
        chk("a_dev_hdr", dev_hdr, mk_hdr(BASE + 40'h8, 1));
        tick();
        cmd_v = 1'b0;
        dresp_v = 1'b1;
        resp_rdy = 1'b1;
        #2;
        chk("a_resp_v", resp_v, 1);
        chk("a_resp_hdr", resp_hdr, dresp_hdr);
        chk("a_resp_crit", resp_crit, dresp_crit);
        chk("a_dresp_rdy", dresp_rdy, 1);
        chk("a_lresp_rdy", lresp_rdy, 0);
        tick();
        #2;
        chk("a_empty_resp_v", resp_v, 0);
        chk("a_empty_dresp_rdy", dresp_rdy, 0);
        dresp_v = 1'b0;
        resp_rdy = 1'b0;

        // Table-driven routing, no responses draining meanwhile
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].addr, 16 + i);
            cmd_v   = vecs[i].v;
            dev_rdy = vecs[i].dr;
            lb_rdy  = vecs[i].lr;
            #2;
            chk($sformatf("v%0d_dev_v", i), dev_v, vecs[i].e_dev);
            chk($sformatf("v%0d_lb_v", i), lb_v, vecs[i].e_lb);
            chk($sformatf("v%0d_rdy", i), cmd_rdy, vecs[i].e_rdy);
            chk($sformatf("v%0d_lb_hdr", i), lb_hdr, mk_hdr(vecs[i].addr, 16 + i));
            chk($sformatf("v%0d_dev_crit", i), dev_crit, 64'hC0DE_0000_0000_0000 + 64'(16 + i));
            tick();
            chk($sformatf("v%0d_err", i), err_cnt, vecs[i].e_err);
        end
        cmd_v = 1'b0;
        dev_rdy = 1'b1;
        lb_rdy = 1'b1;

        // Drain lb, lb, dev with both sources valid throughout
        dresp_v = 1'b1;
        lresp_v = 1'b1;
        resp_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("d%0d_resp_v", k), resp_v, 1);
            chk($sformatf("d%0d_resp_hdr", k), resp_hdr, exp_src[k] ? dresp_hdr : lresp_hdr);
            chk($sformatf("d%0d_dresp_rdy", k), dresp_rdy, exp_src[k]);
            chk($sformatf("d%0d_lresp_rdy", k), lresp_rdy, !exp_src[k]);
            tick();
        end
        #2;
        chk("d_empty_resp_v", resp_v, 0);
        chk("d_empty_dresp_rdy", dresp_rdy, 0);
        chk("d_empty_lresp_rdy", lresp_rdy, 0);
        dresp_v = 1'b0;
        lresp_v = 1'b0;

        // Dev then lb; lb response arrives first and must be held
        tick();
        send(BASE + 40'h40, 40);
        tick();
        send(40'h30_0000, 41);
        tick();
        cmd_v = 1'b0;
        chk("o_err", err_cnt, 3);
        lresp_v = 1'b1;
        #2;
        chk("o_lresp_rdy_held", lresp_rdy, 0);
        chk("o_resp_v_held", resp_v, 0);
        chk("o_resp_hdr_dev", resp_hdr, dresp_hdr);
        tick();
        dresp_v = 1'b1;
        #2;
        chk("o_dev_resp_v", resp_v, 1);
        chk("o_dresp_rdy", dresp_rdy, 1);
        chk("o_lresp_rdy_still", lresp_rdy, 0);
        tick();
        dresp_v = 1'b0;
        #2;
        chk("o_lb_resp_v", resp_v, 1);
        chk("o_lb_resp_hdr", resp_hdr, lresp_hdr);
        chk("o_lresp_rdy", lresp_rdy, 1);
        tick();
        lresp_v = 1'b0;
        #2;
        chk("o_empty_resp_v", resp_v, 0);

        // Fill to els_p = 4; the fifth waits, even across a same-cycle pop
        resp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(BASE + 40'(8 * i), 50 + i);
            #2;
            chk($sformatf("f%0d_rdy", i), cmd_rdy, 1);
            tick();
        end
        send(BASE + 40'h100, 60);
        #2;
        chk("f5_rdy_full", cmd_rdy, 0);
        chk("f5_dev_v_full", dev_v, 0);
        dresp_v = 1'b1;
        resp_rdy = 1'b1;
        #1;
        chk("f5_pop_resp_v", resp_v, 1);
        chk("f5_rdy_pop_same_cycle", cmd_rdy, 0);
        tick();
        dresp_v = 1'b0;
        #2;
        chk("f5_rdy_next", cmd_rdy, 1);
        chk("f5_dev_v_next", dev_v, 1);
        tick();
        cmd_v = 1'b0;
        #2;
        chk("f6_rdy_full_again", cmd_rdy, 0);
        dresp_v = 1'b1;
        tick();
        dresp_v = 1'b0;

        // Async reset with 3 outstanding
        send(BASE + 40'h80, 70);
        dresp_v = 1'b1;
        #2;
        chk("r_pre_resp_v", resp_v, 1);
        rst = 1'b1;
        #1;
        chk("r_cmd_rdy", cmd_rdy, 0);
        chk("r_dev_v", dev_v, 0);
        chk("r_lb_v", lb_v, 0);
        chk("r_resp_v", resp_v, 0);
        chk("r_dresp_rdy", dresp_rdy, 0);
        chk("r_lresp_rdy", lresp_rdy, 0);
        chk("r_err", err_cnt, 0);
        tick();
        cmd_v = 1'b0;
        rst = 1'b0;
        #2;
        chk("r_held_dresp_rdy", dresp_rdy, 0);
        chk("r_held_resp_v", resp_v, 0);
        tick();
        send(BASE + 40'h20, 71);
        #2;
        chk("r_new_dev_v", dev_v, 1);
        chk("r_new_rdy", cmd_rdy, 1);
        tick();
        cmd_v = 1'b0;
        #2;
        chk("r_new_resp_v", resp_v, 1);
        chk("r_new_resp_hdr", resp_hdr, dresp_hdr);
        chk("r_new_dresp_rdy", dresp_rdy, 1);
        tick();
        #2;
        chk("r_new_empty", resp_v, 0);
        dresp_v = 1'b0;

        // Five loopback commands, 2-bit counter saturates at 3
        lresp_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(40'h20_0000 + 40'(8 * i), 80 + i);
            #2;
            chk($sformatf("s%0d_lb_v", i), lb_v, 1);
            chk($sformatf("s%0d_rdy", i), cmd_rdy, 1);
            tick();
            chk($sformatf("s%0d_err", i), err_cnt, (i < 3) ? 64'(i + 1) : 64'd3);
        end
        cmd_v = 1'b0;
        #2;
        chk("s_last_resp_v", resp_v, 1);
        tick();
        #2;
        chk("s_drained", resp_v, 0);
        chk("s_err_final", err_cnt, 3);
        lresp_v = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
